alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issuing front-end for the combinational 32-bit ALU. It accepts one operation request at a time over a valid/ready handshake and drives the ALU operand, control and set lines from registers. It captures the ALU result, keeps the architectural Z/N flag register, and applies conditional execution against those flags. It returns the result over a second valid/ready handshake to the calculator control path.

Parameters:
WIDTH, 32, operand/result width; must match ALU datapath
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_op  in  4  ALU control code (0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr, others give all-ones)
req_a  in  WIDTH  operand 1
req_b  in  WIDTH  operand 2
req_set  in  1  update flags from this result
req_cond  in  2  0 always, 1 if Z, 2 if N, 3 if not Z
alu_dat1  out  WIDTH  to ALU dat1, registered
alu_dat2  out  WIDTH  to ALU dat2, registered
alu_control  out  4  to ALU control, registered
alu_set  out  1  to ALU set, registered
alu_result  in  WIDTH  from ALU result, combinational function of alu_* outputs
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result; 0 when skipped
rsp_skipped  out  1  condition failed, ALU not used
flag_z  out  1  architectural zero flag
flag_n  out  1  architectural negative flag
ops_done  out  CNT_W  count of executed (non-skipped) operations, wraps

Behaviour:
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_skipped 0, flag_z 0, flag_n 0, ops_done 0, and all alu_* outputs 0.
- Reset mid-operation abandons the in-flight op: no response, flags unchanged from reset values.
- FSM states: IDLE, ISSUE, RESP.
- req_ready = (state == IDLE). rsp_valid = (state == RESP).
- IDLE, accept when req_valid && req_ready (cycle T). Condition is evaluated against flag_z/flag_n as held at T.
  - Condition passes: load alu_dat1 = req_a, alu_dat2 = req_b, alu_control = req_op, alu_set = req_set. Go to ISSUE.
  - Condition fails: rsp_result = 0, rsp_skipped = 1. Go to RESP (rsp_valid at T+1). alu_* and flags are unchanged.
- ISSUE (one cycle, T+1): alu_* outputs stable. At end of cycle:
  - rsp_result = alu_result, rsp_skipped = 0, ops_done += 1 (wraps at 2^CNT_W).
  - If alu_set is 1: flag_z = (alu_result == 0), flag_n = alu_result[WIDTH-1]. Flags are computed locally and do not depend on ALU flag outputs.
  - Go to RESP; rsp_valid asserts at T+2.
- RESP: rsp_result and rsp_skipped hold stable while rsp_valid && !rsp_ready. On rsp_ready, go to IDLE.
- No accept is possible in the same cycle as response completion. Minimum spacing is 3 cycles per executed op and 2 per skipped op.
- alu_* outputs hold their last issued values when not in ISSUE.
- Arithmetic is modulo 2^WIDTH; result overflow is not flagged (no C/V).
- Opcodes 6–15 are forwarded unchanged. The ALU returns all-ones for them, so a set op yields N=1, Z=0.
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
- Reset, then add a=5 b=7 set=1 cond=0 -> rsp_valid at T+2, rsp_result 12, Z=0, N=0, ops_done 1.
- sub a=3 b=3 set=1, then op cond=1 (if Z) add 1+1 -> first result 0, Z=1; second executes, result 2, skipped 0.
- sub a=1 b=2 set=1 -> result 0xFFFFFFFF, N=1, Z=0; then cond=3 op with Z=0 -> executes. Finally cond=1 -> skipped, result 0, response at T+1, flags and ops_done unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 and new operands -> rsp_result stable, req_ready 0, second request accepted only in the cycle after rsp_ready.
- op=9 set=1 -> result 0xFFFFFFFF, N=1. Then op=4 (lsl) 1<<31 with set=0 -> result 0x80000000, flags unchanged.
- Assert rst during ISSUE -> next cycle IDLE, rsp_valid 0, flags 0, ops_done 0, alu_* 0; the following request completes normally.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the calculator control path and the ALU sequencer.
// Ports: req_* carry one ALU operation (opcode, operands, flag-update, condition) under valid/ready;
//        rsp_* return the captured result and a skipped marker under valid/ready.
interface alu_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_set;
   logic [1:0]       req_cond;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_skipped;

   // Control path side: issues requests, consumes responses.
   modport master (
      output req_valid, req_op, req_a, req_b, req_set, req_cond, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_skipped
   );

   // Sequencer side: accepts requests, produces responses.
   modport slave (
      input  req_valid, req_op, req_a, req_b, req_set, req_cond, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_skipped
   );
endinterface

// File: rtl/alu_sequencer.sv
// Issuing front-end for the combinational ALU: registers operands/control, captures result, owns Z/N flags.
// Latency: response valid 2 cycles after accept for an executed op, 1 cycle for a condition-skipped op.
// Backpressure: one op in flight; req_ready low until the response is taken, response held while rsp_ready is low.
//
// Ports: clk/rst        - clock and synchronous active-high reset
//        bus (slave)    - request/response handshakes (see alu_sequencer_if)
//        alu_dat1/2, alu_control, alu_set - registered drive into the ALU
//        alu_result     - combinational ALU result for the registered drive
//        flag_z/flag_n  - architectural flags, updated only by executed ops with set=1
//        ops_done       - wrapping count of executed (non-skipped) ops
module alu_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_sequencer_if.slave   bus,
   output logic [WIDTH-1:0] alu_dat1,
   output logic [WIDTH-1:0] alu_dat2,
   output logic [3:0]       alu_control,
   output logic             alu_set,
   input  logic [WIDTH-1:0] alu_result,
   output logic             flag_z,
   output logic             flag_n,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state;
   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_skipped_q;
   logic             cond_pass;

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_skipped = rsp_skipped_q;

   // Condition is judged against the flags as they stand in the accept cycle.
   always_comb begin
      cond_pass = 1'b1;
      case (bus.req_cond)
         2'd0:    cond_pass = 1'b1;
         2'd1:    cond_pass = flag_z;
         2'd2:    cond_pass = flag_n;
         default: cond_pass = !flag_z;
      endcase
   end

   // req_ready and rsp_valid are registered copies of (state==IDLE) and
   // (state==RESP); every state transition updates them together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_skipped_q <= 1'b0;
         flag_z        <= 1'b0;
         flag_n        <= 1'b0;
         ops_done      <= '0;
         alu_dat1      <= '0;
         alu_dat2      <= '0;
         alu_control   <= 4'd0;
         alu_set       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  if (cond_pass) begin
                     alu_dat1    <= bus.req_a;
                     alu_dat2    <= bus.req_b;
                     alu_control <= bus.req_op;
                     alu_set     <= bus.req_set;
                     state       <= ISSUE;
                  end else begin
                     // Skipped op never touches the ALU drive or the flags.
                     rsp_result_q  <= '0;
                     rsp_skipped_q <= 1'b1;
                     rsp_valid_q   <= 1'b1;
                     state         <= RESP;
                  end
               end
            end

            ISSUE: begin
               // ALU inputs have been stable for the whole cycle; sample its output.
               rsp_result_q  <= alu_result;
               rsp_skipped_q <= 1'b0;
               ops_done      <= ops_done + CNT_W'(1);
               if (alu_set) begin
                  flag_z <= (alu_result == '0);
                  flag_n <= alu_result[WIDTH-1];
               end
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end

            RESP: begin
               // Returning to IDLE here means a new request can only be taken next cycle.
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural combinational ALU model.
// Latency: checks response timing of 2 cycles (executed) and 1 cycle (skipped) after accept.
// Backpressure: holds rsp_ready low to check response stability and accept spacing.
module tb_alu_sequencer;
   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] alu_dat1;
   logic [WIDTH-1:0] alu_dat2;
   logic [3:0]       alu_control;
   logic             alu_set;
   logic [WIDTH-1:0] alu_result;
   logic             flag_z;
   logic             flag_n;
   logic [CNT_W-1:0] ops_done;

   int errors = 0;
   int checks = 0;
   int lat;

   alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .alu_dat1    (alu_dat1),
      .alu_dat2    (alu_dat2),
      .alu_control (alu_control),
      .alu_set     (alu_set),
      .alu_result  (alu_result),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .ops_done    (ops_done)
   );

   always #5 clk = ~clk;

   // Reference ALU: pure function of the registered drive lines.
   always_comb begin
      case (alu_control)
         4'd0:    alu_result = alu_dat1 + alu_dat2;
         4'd1:    alu_result = alu_dat1 - alu_dat2;
         4'd2:    alu_result = alu_dat1 * alu_dat2;
         4'd3:    alu_result = alu_dat1 | alu_dat2;
         4'd4:    alu_result = alu_dat1 << alu_dat2;
         4'd5:    alu_result = alu_dat1 >> alu_dat2;
         default: alu_result = '1;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge (it is taken only if req_ready is high).
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic set, input logic [1:0] cond);
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_set   = set;
      bus.req_cond  = cond;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Cycles after the accept edge until rsp_valid, bounded.
   task automatic wait_rsp(output int n);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic complete();
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("post_rsp_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rsp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
   endtask

   task automatic check_rsp(input string tag, input int n_exp, input logic [31:0] res,
                            input logic skip, input logic z, input logic nf, input int ops);
      chk({tag, "_latency"}, 32'(lat), 32'(n_exp));
      chk({tag, "_result"},  bus.rsp_result, res);
      chk({tag, "_skipped"}, 32'(bus.rsp_skipped), 32'(skip));
      chk({tag, "_z"},       32'(flag_z), 32'(z));
      chk({tag, "_n"},       32'(flag_n), 32'(nf));
      chk({tag, "_ops"},     32'(ops_done), 32'(ops));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_set   = 1'b0;
      bus.req_cond  = 2'd0;
      bus.rsp_ready = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_result", bus.rsp_result, 32'd0);
      chk("rst_rsp_skipped", 32'(bus.rsp_skipped), 32'd0);
      chk("rst_flag_z", 32'(flag_z), 32'd0);
      chk("rst_flag_n", 32'(flag_n), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_alu_dat1", alu_dat1, 32'd0);
      chk("rst_alu_dat2", alu_dat2, 32'd0);
      chk("rst_alu_control", 32'(alu_control), 32'd0);
      chk("rst_alu_set", 32'(alu_set), 32'd0);

      // add 5+7 set, always
      issue(4'd0, 32'd5, 32'd7, 1'b1, 2'd0);
      chk("add_issue_req_ready", 32'(bus.req_ready), 32'd0);
      chk("add_issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("add_alu_dat1", alu_dat1, 32'd5);
      chk("add_alu_dat2", alu_dat2, 32'd7);
      chk("add_alu_set", 32'(alu_set), 32'd1);
      wait_rsp(lat);
      check_rsp("add", 1, 32'd12, 1'b0, 1'b0, 1'b0, 1);
      complete();

      // sub 3-3 set -> Z; then add 1+1 if Z (set=0 keeps Z)
      issue(4'd1, 32'd3, 32'd3, 1'b1, 2'd0);
      wait_rsp(lat);
      check_rsp("sub_zero", 1, 32'd0, 1'b0, 1'b1, 1'b0, 2);
      complete();
      issue(4'd0, 32'd1, 32'd1, 1'b0, 2'd1);
      wait_rsp(lat);
      check_rsp("ifz_add", 1, 32'd2, 1'b0, 1'b1, 1'b0, 3);
      complete();

      // sub 1-2 set -> negative; if-not-Z executes; if-Z skipped
      issue(4'd1, 32'd1, 32'd2, 1'b1, 2'd0);
      wait_rsp(lat);
      check_rsp("sub_neg", 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 4);
      complete();
      issue(4'd0, 32'd4, 32'd4, 1'b0, 2'd3);
      wait_rsp(lat);
      check_rsp("ifnz_add", 1, 32'd8, 1'b0, 1'b0, 1'b1, 5);
      complete();
      issue(4'd0, 32'd9, 32'd9, 1'b1, 2'd1);
      wait_rsp(lat);
      check_rsp("ifz_skip", 0, 32'd0, 1'b1, 1'b0, 1'b1, 5);
      chk("skip_alu_dat1_hold", alu_dat1, 32'd4);
      chk("skip_alu_set_hold", 32'(alu_set), 32'd0);
      complete();

      // if-N mul executes (clears N), then if-N skipped
      issue(4'd2, 32'd6, 32'd7, 1'b1, 2'd2);
      wait_rsp(lat);
      check_rsp("ifn_mul", 1, 32'd42, 1'b0, 1'b0, 1'b0, 6);
      complete();
      issue(4'd3, 32'd1, 32'd2, 1'b1, 2'd2);
      wait_rsp(lat);
      check_rsp("ifn_skip", 0, 32'd0, 1'b1, 1'b0, 1'b0, 6);
      complete();

      // Backpressure: response held while a new request waits
      issue(4'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0, 2'd0);
      wait_rsp(lat);
      check_rsp("or", 1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 7);
      bus.req_op    = 4'd5;
      bus.req_a     = 32'h0000_0100;
      bus.req_b     = 32'd4;
      bus.req_set   = 1'b0;
      bus.req_cond  = 2'd0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_result", bus.rsp_result, 32'h0000_00FF);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp_done_req_ready", 32'(bus.req_ready), 32'd1);
      chk("bp_no_same_cycle_accept", alu_dat1, 32'h0000_00F0);
      tick();
      bus.req_valid = 1'b0;
      chk("bp_accept_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_accept_alu_dat1", alu_dat1, 32'h0000_0100);
      wait_rsp(lat);
      check_rsp("lsr", 1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 8);
      complete();

      // Undefined opcode gives all-ones; lsl without set leaves flags
      issue(4'd9, 32'd3, 32'd4, 1'b1, 2'd0);
      chk("op9_alu_control", 32'(alu_control), 32'd9);
      wait_rsp(lat);
      check_rsp("op9", 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 9);
      complete();
      issue(4'd4, 32'd1, 32'd31, 1'b0, 2'd0);
      wait_rsp(lat);
      check_rsp("lsl", 1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 10);
      complete();

      // Reset during ISSUE abandons the op
      issue(4'd0, 32'd2, 32'd2, 1'b1, 2'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_flag_z", 32'(flag_z), 32'd0);
      chk("midrst_flag_n", 32'(flag_n), 32'd0);
      chk("midrst_ops_done", 32'(ops_done), 32'd0);
      chk("midrst_alu_dat1", alu_dat1, 32'd0);
      chk("midrst_alu_control", 32'(alu_control), 32'd0);
      tick();
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      issue(4'd1, 32'd10, 32'd3, 1'b1, 2'd0);
      wait_rsp(lat);
      check_rsp("after_rst", 1, 32'd7, 1'b0, 1'b0, 1'b0, 1);
      complete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
